// File: rtl/parking_gate_arbiter_if.sv
// Gate-side and manager-side signal bundle for parking_gate_arbiter.
// The arbiter connects through the slave modport; gates/manager model use master.
interface parking_gate_arbiter_if #(
    parameter int NUM_GATES = 4
);
    logic [NUM_GATES-1:0] gate_req;
    logic [NUM_GATES-1:0] gate_dir;
    logic [NUM_GATES-1:0] gate_uni;
    logic [NUM_GATES-1:0] gate_ack;
    logic                 gate_ok;
    logic [NUM_GATES-1:0] barrier_open;
    logic [9:0]           uni_parked_car;
    logic [9:0]           parked_car;
    logic                 uni_is_vacated_space;
    logic                 is_vacated_space;
    logic                 car_entered;
    logic                 is_uni_car_entered;
    logic                 car_exited;
    logic                 is_uni_car_exited;
    logic [15:0]          deny_count;

    modport slave (
        input  gate_req, gate_dir, gate_uni,
        input  uni_parked_car, parked_car, uni_is_vacated_space, is_vacated_space,
        output gate_ack, gate_ok, barrier_open,
        output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        output deny_count
    );

    modport master (
        output gate_req, gate_dir, gate_uni,
        output uni_parked_car, parked_car, uni_is_vacated_space, is_vacated_space,
        input  gate_ack, gate_ok, barrier_open,
        input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        input  deny_count
    );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Round-robin arbiter sharing one Parking_management event port among several gates.
// Optional denied-request counter enabled by defining PARK_ARB_STATS_EN.
module parking_gate_arbiter #(
    parameter int NUM_GATES   = 4,
    parameter int OPEN_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    parking_gate_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
    localparam int TMR_W = $clog2(OPEN_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_GATES - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(OPEN_CYCLES);
    localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PULSE  = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_last;
    logic [IDX_W-1:0]     r_win;
    logic [IDX_W-1:0]     w_win;
    logic                 r_verdict;
    logic                 w_verdict;
    logic                 w_found;
    logic [NUM_GATES-1:0] w_elig;
    logic [NUM_GATES-1:0] r_gate_ack;
    logic [NUM_GATES-1:0] w_gate_ack;
    logic                 r_gate_ok;
    logic                 w_gate_ok;
    logic [NUM_GATES-1:0] w_load;
    logic [NUM_GATES-1:0] r_barrier;
    // event bits: {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited}
    logic [3:0]           r_evt;
    logic [3:0]           w_evt;
    logic [TMR_W-1:0]     r_timer     [NUM_GATES];
    logic [TMR_W-1:0]     w_timer_nxt [NUM_GATES];

    function automatic logic admit(
        input logic       dir,
        input logic       uni,
        input logic       uni_vac,
        input logic       vac,
        input logic [9:0] uni_cnt,
        input logic [9:0] cnt
    );
        logic ok;
        if (dir) begin
            ok = uni ? uni_vac : vac;
        end else begin
            ok = uni ? (uni_cnt != 10'd0) : (cnt != 10'd0);
        end
        return ok;
    endfunction

    assign w_elig = bus.gate_req & ~r_barrier;

    // Round-robin winner search starting just after the last served gate.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last;
        for (int k = 1; k <= NUM_GATES; k++) begin
            if (!w_found && w_elig[IDX_W'((int'(r_last) + k) % NUM_GATES)]) begin
                w_found = 1'b1;
                w_win   = IDX_W'((int'(r_last) + k) % NUM_GATES);
            end else begin
                w_found = w_found;
            end
        end
    end

    assign w_verdict = admit(bus.gate_dir[w_win], bus.gate_uni[w_win],
                             bus.uni_is_vacated_space, bus.is_vacated_space,
                             bus.uni_parked_car, bus.parked_car);

    // Next state plus next values of the registered outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_evt       = 4'b0000;
        w_gate_ack  = {NUM_GATES{1'b0}};
        w_gate_ok   = 1'b0;
        w_load      = {NUM_GATES{1'b0}};
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_PULSE;
                    if (w_verdict) begin
                        w_evt = bus.gate_dir[w_win] ? {1'b1, bus.gate_uni[w_win], 2'b00}
                                                    : {2'b00, 1'b1, bus.gate_uni[w_win]};
                    end else begin
                        w_evt = 4'b0000;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PULSE: begin
                w_state_nxt       = S_SETTLE;
                w_gate_ack[r_win] = 1'b1;
                w_gate_ok         = r_verdict;
                w_load[r_win]     = r_verdict;
            end
            S_SETTLE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Barrier timers: load on acceptance, otherwise count down to zero.
    always_comb begin
        for (int i = 0; i < NUM_GATES; i++) begin
            if (w_load[i]) begin
                w_timer_nxt[i] = TMR_LOAD;
            end else if (r_timer[i] != TMR_ZERO) begin
                w_timer_nxt[i] = r_timer[i] - TMR_ONE;
            end else begin
                w_timer_nxt[i] = r_timer[i];
            end
        end
    end

    // FSM state and captured transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_last    <= LAST_RST;
            r_win     <= {IDX_W{1'b0}};
            r_verdict <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && w_found) begin
                r_last    <= w_win;
                r_win     <= w_win;
                r_verdict <= w_verdict;
            end else begin
                r_last    <= r_last;
                r_win     <= r_win;
                r_verdict <= r_verdict;
            end
        end
    end

    // Registered outputs and barrier timers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt      <= 4'b0000;
            r_gate_ack <= {NUM_GATES{1'b0}};
            r_gate_ok  <= 1'b0;
            r_barrier  <= {NUM_GATES{1'b0}};
            for (int i = 0; i < NUM_GATES; i++) begin
                r_timer[i] <= TMR_ZERO;
            end
        end else begin
            r_evt      <= w_evt;
            r_gate_ack <= w_gate_ack;
            r_gate_ok  <= w_gate_ok;
            for (int i = 0; i < NUM_GATES; i++) begin
                r_timer[i]   <= w_timer_nxt[i];
                r_barrier[i] <= (w_timer_nxt[i] != TMR_ZERO);
            end
        end
    end

    assign bus.car_entered        = r_evt[3];
    assign bus.is_uni_car_entered = r_evt[2];
    assign bus.car_exited         = r_evt[1];
    assign bus.is_uni_car_exited  = r_evt[0];
    assign bus.gate_ack           = r_gate_ack;
    assign bus.gate_ok            = r_gate_ok;
    assign bus.barrier_open       = r_barrier;

`ifdef PARK_ARB_STATS_EN
    logic [15:0] r_deny_count;

    // Saturating count of denials, updated as the deny ack is raised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deny_count <= 16'd0;
        end else if ((r_state == S_PULSE) && !r_verdict && (r_deny_count != 16'hFFFF)) begin
            r_deny_count <= r_deny_count + 16'd1;
        end else begin
            r_deny_count <= r_deny_count;
        end
    end

    assign bus.deny_count = r_deny_count;
`else
    assign bus.deny_count = 16'd0;
`endif

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed self-checking bench for parking_gate_arbiter (NUM_GATES=4, OPEN_CYCLES=8).
module tb_parking_gate_arbiter;
    localparam int NG = 4;
    localparam int OC = 8;
`ifdef PARK_ARB_STATS_EN
    localparam logic STATS = 1'b1;
`else
    localparam logic STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_err    = 0;
    logic [3:0] evt;

    parking_gate_arbiter_if #(.NUM_GATES(NG)) bus ();

    parking_gate_arbiter #(.NUM_GATES(NG), .OPEN_CYCLES(OC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign evt = {bus.car_entered, bus.is_uni_car_entered, bus.car_exited, bus.is_uni_car_exited};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n                    = 1'b0;
        bus.gate_req             = 4'b0000;
        bus.gate_dir             = 4'b0000;
        bus.gate_uni             = 4'b0000;
        bus.uni_parked_car       = 10'd0;
        bus.parked_car           = 10'd0;
        bus.uni_is_vacated_space = 1'b0;
        bus.is_vacated_space     = 1'b0;
        step();
        step();
        check("rst_ack", 32'(bus.gate_ack), 32'h0);
        check("rst_ok", 32'(bus.gate_ok), 32'h0);
        check("rst_barrier", 32'(bus.barrier_open), 32'h0);
        check("rst_evt", 32'(evt), 32'h0);
        check("rst_deny", 32'(bus.deny_count), 32'h0);
        rst_n = 1'b1;

        // Gate 0 uni entry, accepted.
        bus.uni_is_vacated_space = 1'b1;
        bus.gate_req = 4'b0001;
        bus.gate_dir = 4'b0001;
        bus.gate_uni = 4'b0001;
        step();
        check("t1_pulse", 32'(evt), 32'hC);
        check("t1_pulse_noack", 32'(bus.gate_ack), 32'h0);
        step();
        check("t1_ack", 32'(bus.gate_ack), 32'h1);
        check("t1_ok", 32'(bus.gate_ok), 32'h1);
        check("t1_evt_clear", 32'(evt), 32'h0);
        check("t1_barrier_c1", 32'(bus.barrier_open), 32'h1);
        bus.gate_req = 4'b0000;
        for (int c = 2; c <= OC; c++) begin
            step();
            check("t1_barrier_open", 32'(bus.barrier_open), 32'h1);
        end
        step();
        check("t1_barrier_closed", 32'(bus.barrier_open), 32'h0);

        // Fresh reset so gate 0 wins first; four simultaneous non-uni entries.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.is_vacated_space = 1'b1;
        bus.gate_req = 4'b1111;
        bus.gate_dir = 4'b1111;
        bus.gate_uni = 4'b0000;
        for (int g = 0; g < NG; g++) begin
            step();
            check("t2_pulse", 32'(evt), 32'h8);
            check("t2_pulse_noack", 32'(bus.gate_ack), 32'h0);
            step();
            check("t2_ack_order", 32'(bus.gate_ack), 32'(1 << g));
            check("t2_ok", 32'(bus.gate_ok), 32'h1);
            check("t2_evt_clear", 32'(evt), 32'h0);
            bus.gate_req[g] = 1'b0;
            step();
            check("t2_quiet_ack", 32'(bus.gate_ack), 32'h0);
            check("t2_quiet_evt", 32'(evt), 32'h0);
        end
        for (int c = 0; c < 10; c++) begin
            step();
        end
        check("t2_all_closed", 32'(bus.barrier_open), 32'h0);

        // Gate 2 non-uni entry with no vacancy: denied.
        bus.is_vacated_space = 1'b0;
        bus.gate_req = 4'b0100;
        bus.gate_dir = 4'b0100;
        bus.gate_uni = 4'b0000;
        step();
        check("t3_no_pulse", 32'(evt), 32'h0);
        step();
        check("t3_ack", 32'(bus.gate_ack), 32'h4);
        check("t3_ok", 32'(bus.gate_ok), 32'h0);
        check("t3_deny", 32'(bus.deny_count), STATS ? 32'd1 : 32'd0);
        bus.gate_req = 4'b0000;
        step();
        check("t3_barrier_shut", 32'(bus.barrier_open), 32'h0);

        // Gate 1 uni exit with zero uni cars: denied, then accepted at 470.
        bus.uni_parked_car = 10'd0;
        bus.gate_req = 4'b0010;
        bus.gate_dir = 4'b0000;
        bus.gate_uni = 4'b0010;
        step();
        check("t4_no_pulse", 32'(evt), 32'h0);
        step();
        check("t4_deny_ack", 32'(bus.gate_ack), 32'h2);
        check("t4_deny_ok", 32'(bus.gate_ok), 32'h0);
        check("t4_deny_cnt", 32'(bus.deny_count), STATS ? 32'd2 : 32'd0);
        bus.uni_parked_car = 10'd470;
        step();
        step();
        check("t4_exit_pulse", 32'(evt), 32'h3);
        step();
        check("t4_exit_ack", 32'(bus.gate_ack), 32'h2);
        check("t4_exit_ok", 32'(bus.gate_ok), 32'h1);

        // Gate 1 keeps requesting: no regrant while its barrier is open.
        for (int c = 1; c <= OC; c++) begin
            step();
            check("t5_hold_ack", 32'(bus.gate_ack), 32'h0);
            check("t5_hold_evt", 32'(evt), 32'h0);
        end
        check("t5_barrier_closed", 32'(bus.barrier_open), 32'h0);
        step();
        check("t5_regrant_pulse", 32'(evt), 32'h3);
        step();
        check("t5_regrant_ack", 32'(bus.gate_ack), 32'h2);
        check("t5_regrant_ok", 32'(bus.gate_ok), 32'h1);
        bus.gate_req = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            step();
        end

        // Reset dropped while gate 0's pulse is high.
        bus.gate_req = 4'b0001;
        bus.gate_dir = 4'b0001;
        bus.gate_uni = 4'b0001;
        step();
        check("t6_pulse", 32'(evt), 32'hC);
        #2;
        rst_n = 1'b0;
        bus.gate_req = 4'b0000;
        #1;
        check("t6_rst_evt", 32'(evt), 32'h0);
        check("t6_rst_ack", 32'(bus.gate_ack), 32'h0);
        step();
        check("t6_rst_held_ack", 32'(bus.gate_ack), 32'h0);
        rst_n = 1'b1;
        step();
        check("t6_release_evt", 32'(evt), 32'h0);
        check("t6_release_ack", 32'(bus.gate_ack), 32'h0);
        bus.gate_req = 4'b0001;
        step();
        check("t6_fresh_pulse", 32'(evt), 32'hC);
        step();
        check("t6_fresh_ack", 32'(bus.gate_ack), 32'h1);
        check("t6_fresh_ok", 32'(bus.gate_ok), 32'h1);
        check("t6_deny_cleared", 32'(bus.deny_count), 32'h0);
        bus.gate_req = 4'b0000;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
